// File: rtl/cla_seq_add_ctrl_pkg.sv
// Shared types and default sizing for the sequential CLA adder controller.
package cla_seq_pkg;
  localparam int DEF_WIDTH = 64;
  localparam int DEF_SLICE = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/cla_seq_add_ctrl_if.sv
// Request/response bundle for cla_seq_add_ctrl; the sub port exists only with CLA_SEQ_SUB_EN.
interface cla_seq_add_ctrl_if #(parameter int WIDTH = cla_seq_pkg::DEF_WIDTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef CLA_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef CLA_SEQ_SUB_EN
  modport master (output in_valid, a, b, cin, sub, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`else
  modport master (output in_valid, a, b, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, busy);
  modport slave  (input  in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/cla_seq_add_ctrl_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice (propagate/generate + carry chain).
module cla_slice #(
  parameter int SLICE = cla_seq_pkg::DEF_SLICE
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             c_i,
  output logic [SLICE-1:0] s_o,
  output logic             c_o
);
  logic [SLICE-1:0] p, g;
  logic [SLICE:0]   c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  always_comb begin
    c[0] = c_i;
    for (int i = 0; i < SLICE; i++)
      c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign s_o = p ^ c[SLICE-1:0];
  assign c_o = c[SLICE];
endmodule

// File: rtl/cla_seq_add_ctrl.sv
// Sequential wide adder: one request time-shares a single CLA slice over WIDTH/SLICE cycles.
// Optional subtract mode is compiled in with CLA_SEQ_SUB_EN.
module cla_seq_add_ctrl
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic              clk,
  input  logic              rst,
  cla_seq_add_ctrl_if.slave io
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE) != 0 || NSLICE < 1) begin : g_bad_cfg
    $error("cla_seq_add_ctrl: WIDTH must be a positive multiple of SLICE");
  end

  typedef logic [NSLICE-1:0][SLICE-1:0] vec_t;

  state_e          state_q, state_d;
  vec_t            a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            accept, sub_w;
  logic [SLICE-1:0] sl_s;
  logic            sl_co;

`ifdef CLA_SEQ_SUB_EN
  assign sub_w = io.sub;
`else
  assign sub_w = 1'b0;
`endif

  assign io.in_ready  = (state_q == IDLE) | ((state_q == DONE) & io.out_ready);
  assign accept       = io.in_valid & io.in_ready;
  assign io.out_valid = (state_q == DONE);
  assign io.busy      = (state_q != IDLE);
  assign io.sum       = sum_q;
  assign io.cout      = cout_q;

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a_i (a_q[idx_q]),
    .b_i (b_q[idx_q]),
    .c_i (carry_q),
    .s_o (sl_s),
    .c_o (sl_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: ;
      RUN: begin
        sum_d[idx_q] = sl_s;
        carry_d      = sl_co;
        if (idx_q == IW'(NSLICE - 1)) begin
          cout_d  = sl_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Accept is only possible from IDLE/DONE, so it never collides with RUN updates.
    if (accept) begin
      a_d     = io.a;
      b_d     = sub_w ? ~io.b : io.b;
      carry_d = sub_w ? 1'b1 : io.cin;
      idx_d   = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// Randomized scoreboard bench for cla_seq_add_ctrl (add mode; subtract when CLA_SEQ_SUB_EN).
module tb_cla_seq_add_ctrl;
  localparam int W  = 64;
  localparam int S  = 16;
  localparam int NS = W / S;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cla_seq_add_ctrl_if #(.WIDTH(W)) bus ();
  cla_seq_add_ctrl #(.WIDTH(W), .SLICE(S)) dut (.clk(clk), .rst(rst), .io(bus));

  logic [W:0] exp_q[$];
  int         acc_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic cin, sub);
    if (sub) return {1'b0, a} - {1'b0, b} + (1'b1 << W);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Scoreboard monitor: latency on each out_valid rise, value on each handshake.
  always @(negedge clk) begin
    prev_ov <= bus.out_valid;
    if (rst && bus.out_valid && !prev_ov) begin
      if (acc_q.size() == 0) chk("latency_noreq", 1, 0);
      else chk("latency", (W+1)'(cyc - acc_q.pop_front()), NS);
    end
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", {bus.cout, bus.sum}, 0);
      else chk("result", {bus.cout, bus.sum}, exp_q.pop_front());
    end
  end

  task automatic send(input logic [W-1:0] a, b, input logic cin, sub);
    int   n = 0;
    logic s;
`ifdef CLA_SEQ_SUB_EN
    s = sub;
    bus.sub = sub;
`else
    s = sub & 1'b0;
`endif
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      chk("accept_timeout", 1, 0);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    exp_q.push_back(model(a, b, cin, s));
    acc_q.push_back(cyc);
    bus.in_valid = 1'b0;
    bus.a = {$urandom, $urandom}; bus.b = {$urandom, $urandom}; bus.cin = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", W+1'(exp_q.size()), 0);
    #1;
  endtask

  initial begin
    int t1, t2, n;
    logic [W:0] held;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    bus.sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sum", bus.sum, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    bus.out_ready = 1'b1;
    send({W{1'b1}}, 64'd1, 1'b0, 1'b0); drain();
    send(64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0); drain();

    // Stall: result must hold while the consumer is not ready.
    bus.out_ready = 1'b0;
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'b0);
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    chk("stall_out_valid", bus.out_valid, 1);
    held = (exp_q.size() != 0) ? exp_q[0] : '0;
    repeat (10) begin
      @(negedge clk);
      chk("stall_hold", {bus.cout, bus.sum}, held);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_busy", bus.busy, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_release_busy", bus.busy, 0);
    chk("stall_release_ov", bus.out_valid, 0);

    // Back-to-back: second request accepted on the first's handshake edge.
    send(64'd3, 64'd4, 1'b0, 1'b0); t1 = cyc;
    send(64'd10, 64'd20, 1'b0, 1'b0); t2 = cyc;
    chk("b2b_gap", (W+1)'(t2 - t1), NS + 1);
    drain();

    // Reset in the middle of RUN discards the in-flight result.
    send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete(); acc_q.delete();
    rst = 1'b1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_sum", bus.sum, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_busy", bus.busy, 0);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_stays_idle", bus.out_valid, 0);
    send(64'd1, 64'd1, 1'b0, 1'b0); drain();

`ifdef CLA_SEQ_SUB_EN
    send(64'd5, 64'd7, 1'b1, 1'b1); drain();
    send(64'd7, 64'd5, 1'b0, 1'b1); drain();
`endif

    // Random traffic with a randomly stalling consumer.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          send({$urandom, $urandom}, (i % 5 == 0) ? {W{1'b1}} : {$urandom, $urandom},
               1'($urandom), 1'($urandom));
        end
        drain();
      end
      begin
        while (exp_q.size() != 0 || acc_q.size() != 0 || cyc < 10) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_any
    bus.out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_seq_add_ctrl.md
# cla_seq_add_ctrl

Sequencing controller for a multi-slice carry-lookahead adder: accepts one WIDTH-bit add request through a valid/ready handshake, then time-shares a single SLICE-bit CLA slice over WIDTH/SLICE cycles, carrying between slices in a register. It sits in front of the wide-adder datapath as the area-reduced alternative to the fully unrolled registered adders, for throughput-insensitive consumers.

## Interface
- WIDTH, 64, operand/result width; must be an integer multiple of SLICE (elaboration error otherwise)
- SLICE, 16, width of the shared CLA slice; NSLICE = WIDTH/SLICE, NSLICE ≥ 1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  controller can accept a request this cycle
- a, b  in  WIDTH  operands, sampled on accept
- cin  in  1  carry-in, sampled on accept
- sub  in  1  subtract select, sampled on accept (present only with CLA_SEQ_SUB_EN)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, registered
- cout  out  1  carry-out of MSB slice, registered
- busy  out  1  high in RUN or DONE

## Operation
- FSM states IDLE, RUN, DONE; reset state IDLE.
- Accept = in_valid & in_ready; in_ready = (state==IDLE) | (state==DONE & out_ready).
- On accept: latch a, b, cin into operand regs; slice index idx ← 0; carry reg ← cin; next state RUN.
- RUN: slice computes a_r[idx], b_r[idx], carry reg; on each edge write sum slice idx, carry reg ← slice cout, idx ← idx+1. When idx==NSLICE-1: cout ← slice cout, next state DONE.
- DONE: out_valid=1; sum/cout stable until out_ready. On out_ready: IDLE, or RUN directly if in_valid in the same cycle (back-to-back accept; new operands latched, sum/cout overwritten slice by slice from the next edge).
- idx counter width max(1, $clog2(NSLICE)); no wrap beyond NSLICE-1; with NSLICE=1, RUN lasts one cycle.
- Arithmetic modulo 2^WIDTH; cout is the true carry of a + b + cin.
- Inputs a, b, cin, sub ignored outside accept cycles; changes during RUN have no effect.
- Reset (any state, incl. mid-RUN): state IDLE, in-flight result discarded.

## Timing
- Reset values: in_ready=1 (after reset released, IDLE), out_valid=0, sum=0, cout=0, busy=0, idx=0, carry reg=0.
- Latency: accept at edge T → out_valid high after edge T+NSLICE (4 cycles for defaults).
- Throughput with out_ready held high: one result per NSLICE+1 cycles.
- out_valid falls on the edge where out_valid & out_ready, unless in NSLICE=… back-to-back: it still falls; rises again NSLICE edges later.
- in_ready is combinational from state and out_ready; no combinational path from in_valid to outputs.

## Configuration
- CLA_SEQ_SUB_EN defined: sub port exists; on accept with sub=1, b_r ← ~b and carry reg ← 1 (cin ignored), giving a − b; cout=1 means no borrow. sub=0 behaves as add.
- Undefined: no sub port; add only.

## Structure
- Package cla_seq_pkg: state enum (IDLE, RUN, DONE), default WIDTH/SLICE constants.
- One sub-module, cla_slice: parameterized SLICE-bit combinational CLA (p/g generate, carry chain, sum); instantiated once, operands selected by idx.

## Test plan
- a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0, cout=1, out_valid exactly 4 cycles after accept.
- a=64'h0000_0000_FFFF_FFFF, b=0, cin=1 → sum=64'h0000_0001_0000_0000, cout=0 (carry crosses slice boundary).
- Result pending, out_ready low 10 cycles → sum/cout stable, in_ready=0, busy=1; then out_ready high → IDLE.
- Back-to-back: in_valid held with two requests (3+4, then 10+20), out_ready=1 → results 7 then 30, second accepted on first's handshake edge.
- rst low for one cycle mid-RUN (idx=2) → out_valid=0, sum=0, in_ready=1 after release; next request 1+1 → sum=2.
- With CLA_SEQ_SUB_EN: a=5, b=7, sub=1 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0; a=7, b=5 → sum=2, cout=1.
